// File: rtl/dmem_bridge_pkg.sv
// Shared types and sizing helpers for the data-memory stream bridge.
package dmem_bridge_pkg;

  typedef enum logic {
    SNK_IDLE,
    SNK_DRAIN
  } snk_state_t;

  typedef enum logic [1:0] {
    SRC_IDLE,
    SRC_READ,
    SRC_EMIT
  } src_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_HOST,
    GNT_SNK,
    GNT_SRC
  } gnt_t;

  function automatic int lanes(input int stream_w, input int word_w);
    return stream_w / word_w;
  endfunction

  function automatic int lane_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width able to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dmem_stream_src.sv
// Source stream engine: issues word reads on granted cycles, tags its own reads
// through an RD_LAT-deep pipe and assembles returned words into one wide beat.
module dmem_stream_src
  import dmem_bridge_pkg::*;
#(
  parameter int STREAM_W = 512,
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int SRC_BASE = 0,
  parameter int LEN_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [LEN_W-1:0]    len,
  input  logic                gnt,
  input  logic [WORD_W-1:0]   core_q,
  output logic                rd_req,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                sop,
  output logic                eop,
  output logic                valid,
  output logic [STREAM_W-1:0] q,
  output logic                busy,
  output logic                pkt_done
);

  localparam int LANES = lanes(STREAM_W, WORD_W);
  localparam int CW    = cnt_w(LANES);

  src_state_t          state;
  logic [CW-1:0]       issued;
  logic [CW-1:0]       returned;
  logic [LEN_W-1:0]    remaining;
  logic                first;
  logic [RD_LAT-1:0]   tag_p;
  logic [STREAM_W-1:0] asm_p;
  logic [STREAM_W-1:0] asm_next;
  logic                issue;
  logic                land;

  assign rd_req   = (state == SRC_READ) && (issued != CW'(LANES));
  assign issue    = rd_req && gnt;
  // Only words whose tag reaches the end of the pipe are ours; host reads pass untagged.
  assign land     = tag_p[RD_LAT-1];
  assign asm_next = (asm_p >> WORD_W) | (STREAM_W'(core_q) << (STREAM_W - WORD_W));

  always_ff @(posedge clk) begin
    if (land) asm_p <= asm_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SRC_IDLE;
      rd_addr   <= '0;
      issued    <= '0;
      returned  <= '0;
      remaining <= '0;
      first     <= 1'b0;
      tag_p     <= '0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      valid     <= 1'b0;
      q         <= '0;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
    end else begin
      tag_p    <= RD_LAT'({tag_p, issue});
      pkt_done <= 1'b0;
      case (state)
        SRC_IDLE: begin
          if (req && (len != '0)) begin
            state     <= SRC_READ;
            remaining <= len;
            rd_addr   <= ADDR_W'(SRC_BASE);
            issued    <= '0;
            returned  <= '0;
            first     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SRC_READ: begin
          if (issue) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            issued  <= issued + CW'(1);
          end
          if (land) begin
            returned <= returned + CW'(1);
            if (returned == CW'(LANES - 1)) begin
              state <= SRC_EMIT;
              q     <= asm_next;
              valid <= 1'b1;
              sop   <= first;
              eop   <= (remaining == LEN_W'(1));
            end
          end
        end
        SRC_EMIT: begin
          valid     <= 1'b0;
          sop       <= 1'b0;
          eop       <= 1'b0;
          first     <= 1'b0;
          remaining <= remaining - LEN_W'(1);
          issued    <= '0;
          returned  <= '0;
          if (eop) begin
            state    <= SRC_IDLE;
            busy     <= 1'b0;
            pkt_done <= 1'b1;
          end else begin
            state <= SRC_READ;
          end
        end
        default: state <= SRC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dmem_stream_bridge.sv
// Arbitrates the core data port between host, sink engine and source engine.
// Optional build macro DMEM_BRIDGE_STATS_EN enables the saturating packet/drop counters.
module dmem_stream_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int STREAM_W = 512,
  parameter int WORD_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int SNK_BASE = 0,
  parameter int SRC_BASE = 0,
  parameter int LEN_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [WORD_W-1:0]   data_din,
  input  logic                data_we,
  input  logic                data_oe,
  output logic [WORD_W-1:0]   data_q,
  input  logic                snk_sop,
  input  logic                snk_eop,
  input  logic                snk_valid,
  input  logic [STREAM_W-1:0] snk_din,
  output logic                snk_ready,
  input  logic                src_req,
  input  logic [LEN_W-1:0]    src_len,
  output logic                src_sop,
  output logic                src_eop,
  output logic                src_valid,
  output logic [STREAM_W-1:0] src_q,
  output logic                src_busy,
  output logic [ADDR_W-1:0]   core_data_addr,
  output logic [WORD_W-1:0]   core_data_din,
  output logic                core_data_we,
  output logic                core_data_oe,
  input  logic [WORD_W-1:0]   core_data_q,
  output logic [31:0]         snk_pkt_cnt,
  output logic [31:0]         src_pkt_cnt,
  output logic [31:0]         snk_drop_cnt
);

  localparam int LANES = lanes(STREAM_W, WORD_W);
  localparam int LIW   = lane_idx_w(LANES);

  snk_state_t          snk_state;
  logic [ADDR_W-1:0]   snk_ptr;
  logic [LIW-1:0]      snk_lane;
  logic                snk_eop_q;
  logic [STREAM_W-1:0] snk_beat;
  gnt_t                gnt;
  logic                snk_gnt;
  logic                src_gnt;
  logic                src_rd_req;
  logic [ADDR_W-1:0]   src_addr;
  logic                snk_done;
  logic                snk_drop;
  logic                src_done;

  // Fixed priority: the host is combinationally passed through whenever it strobes.
  always_comb begin
    gnt = GNT_NONE;
    if (data_we | data_oe)          gnt = GNT_HOST;
    else if (snk_state == SNK_DRAIN) gnt = GNT_SNK;
    else if (src_rd_req)             gnt = GNT_SRC;
  end

  assign snk_gnt = (gnt == GNT_SNK);
  assign src_gnt = (gnt == GNT_SRC);

  always_comb begin
    core_data_addr = '0;
    core_data_din  = '0;
    core_data_we   = 1'b0;
    core_data_oe   = 1'b0;
    case (gnt)
      GNT_HOST: begin
        core_data_addr = data_addr;
        core_data_din  = data_din;
        core_data_we   = data_we;
        core_data_oe   = data_oe;
      end
      GNT_SNK: begin
        core_data_addr = snk_ptr;
        core_data_din  = snk_beat[WORD_W-1:0];
        core_data_we   = 1'b1;
      end
      GNT_SRC: begin
        core_data_addr = src_addr;
        core_data_oe   = 1'b1;
      end
      default: ;
    endcase
  end

  assign data_q    = core_data_q;
  assign snk_ready = (snk_state == SNK_IDLE);
  assign snk_drop  = snk_valid & ~snk_ready;
  assign snk_done  = snk_gnt && (snk_lane == LIW'(LANES - 1)) && snk_eop_q;

  // The beat shifts down one word per granted write so lane 0 is always at the bottom.
  always_ff @(posedge clk) begin
    if ((snk_state == SNK_IDLE) && snk_valid) snk_beat <= snk_din;
    else if (snk_gnt)                         snk_beat <= snk_beat >> WORD_W;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snk_state <= SNK_IDLE;
      snk_ptr   <= ADDR_W'(SNK_BASE);
      snk_lane  <= '0;
      snk_eop_q <= 1'b0;
    end else if (snk_state == SNK_IDLE) begin
      if (snk_valid) begin
        snk_state <= SNK_DRAIN;
        snk_lane  <= '0;
        snk_eop_q <= snk_eop;
        if (snk_sop) snk_ptr <= ADDR_W'(SNK_BASE);
      end
    end else if (snk_gnt) begin
      snk_ptr  <= snk_ptr + ADDR_W'(1);
      snk_lane <= snk_lane + LIW'(1);
      if (snk_lane == LIW'(LANES - 1)) snk_state <= SNK_IDLE;
    end
  end

  dmem_stream_src #(
    .STREAM_W (STREAM_W),
    .WORD_W   (WORD_W),
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT),
    .SRC_BASE (SRC_BASE),
    .LEN_W    (LEN_W)
  ) u_src (
    .clk      (clk),
    .reset    (reset),
    .req      (src_req),
    .len      (src_len),
    .gnt      (src_gnt),
    .core_q   (core_data_q),
    .rd_req   (src_rd_req),
    .rd_addr  (src_addr),
    .sop      (src_sop),
    .eop      (src_eop),
    .valid    (src_valid),
    .q        (src_q),
    .busy     (src_busy),
    .pkt_done (src_done)
  );

`ifdef DMEM_BRIDGE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snk_pkt_cnt  <= '0;
      src_pkt_cnt  <= '0;
      snk_drop_cnt <= '0;
    end else begin
      if (snk_done && (snk_pkt_cnt != '1))  snk_pkt_cnt  <= snk_pkt_cnt + 32'd1;
      if (src_done && (src_pkt_cnt != '1))  src_pkt_cnt  <= src_pkt_cnt + 32'd1;
      if (snk_drop && (snk_drop_cnt != '1)) snk_drop_cnt <= snk_drop_cnt + 32'd1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = snk_done | src_done | snk_drop;
  assign snk_pkt_cnt  = '0;
  assign src_pkt_cnt  = '0;
  assign snk_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_stream_bridge.sv
// Directed bench for dmem_stream_bridge with a small word memory standing in for the core.
module tb_dmem_stream_bridge;

  localparam int STREAM_W = 512;
  localparam int WORD_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int LANES    = 16;
  localparam int RD_LAT   = 2;
  localparam int LEN_W    = 16;
`ifdef DMEM_BRIDGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [ADDR_W-1:0]   data_addr;
  logic [WORD_W-1:0]   data_din;
  logic                data_we;
  logic                data_oe;
  logic [WORD_W-1:0]   data_q;
  logic                snk_sop;
  logic                snk_eop;
  logic                snk_valid;
  logic [STREAM_W-1:0] snk_din;
  logic                snk_ready;
  logic                src_req;
  logic [LEN_W-1:0]    src_len;
  logic                src_sop;
  logic                src_eop;
  logic                src_valid;
  logic [STREAM_W-1:0] src_q;
  logic                src_busy;
  logic [ADDR_W-1:0]   core_data_addr;
  logic [WORD_W-1:0]   core_data_din;
  logic                core_data_we;
  logic                core_data_oe;
  logic [WORD_W-1:0]   core_data_q;
  logic [31:0]         snk_pkt_cnt;
  logic [31:0]         src_pkt_cnt;
  logic [31:0]         snk_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_stream_bridge #(
    .STREAM_W (STREAM_W),
    .WORD_W   (WORD_W),
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT),
    .LEN_W    (LEN_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_addr      (data_addr),
    .data_din       (data_din),
    .data_we        (data_we),
    .data_oe        (data_oe),
    .data_q         (data_q),
    .snk_sop        (snk_sop),
    .snk_eop        (snk_eop),
    .snk_valid      (snk_valid),
    .snk_din        (snk_din),
    .snk_ready      (snk_ready),
    .src_req        (src_req),
    .src_len        (src_len),
    .src_sop        (src_sop),
    .src_eop        (src_eop),
    .src_valid      (src_valid),
    .src_q          (src_q),
    .src_busy       (src_busy),
    .core_data_addr (core_data_addr),
    .core_data_din  (core_data_din),
    .core_data_we   (core_data_we),
    .core_data_oe   (core_data_oe),
    .core_data_q    (core_data_q),
    .snk_pkt_cnt    (snk_pkt_cnt),
    .src_pkt_cnt    (src_pkt_cnt),
    .snk_drop_cnt   (snk_drop_cnt)
  );

  always #5 clk = ~clk;

  // Core data memory with a two-cycle registered read path.
  logic [31:0] mem [0:63];
  logic [31:0] rd_p1;
  logic [31:0] rd_p2;
  always @(posedge clk) begin
    if (core_data_we) mem[core_data_addr[5:0]] <= core_data_din;
    if (core_data_oe) rd_p1 <= mem[core_data_addr[5:0]];
    rd_p2 <= rd_p1;
  end
  assign core_data_q = rd_p2;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [STREAM_W-1:0] make_beat(input logic [31:0] base);
    logic [STREAM_W-1:0] b;
    b = '0;
    for (int i = 0; i < LANES; i++) b[i*WORD_W +: WORD_W] = base + 32'(i);
    return b;
  endfunction

  task automatic send_beat(input logic sop, input logic eop, input logic [STREAM_W-1:0] beat);
    snk_sop   = sop;
    snk_eop   = eop;
    snk_din   = beat;
    snk_valid = 1'b1;
    tick();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
    #1;
  endtask

  task automatic host_wr(input logic [31:0] addr, input logic [31:0] dat);
    data_addr = addr;
    data_din  = dat;
    data_we   = 1'b1;
    tick();
    data_we   = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!snk_ready && n < 100) begin
      tick();
      n++;
    end
    check_val(tag, snk_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    bit seen;
    logic p0_v, p1_v, host_rd;
    logic [31:0] p0_a, p1_a;

    reset = 1'b1; data_addr = '0; data_din = '0; data_we = 1'b0; data_oe = 1'b0;
    snk_sop = 1'b0; snk_eop = 1'b0; snk_valid = 1'b0; snk_din = '0;
    src_req = 1'b0; src_len = '0;
    #1;
    check_val("rst_snk_ready", snk_ready, 1'b1);
    check_val("rst_src_busy", src_busy, 1'b0);
    check_val("rst_src_valid", src_valid, 1'b0);
    check_val("rst_core_we", core_data_we, 1'b0);
    check_val("rst_core_oe", core_data_oe, 1'b0);
    check_val("rst_snk_pkt", snk_pkt_cnt, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Single sop+eop beat drains to words 0..15 in consecutive cycles.
    check_val("t1_ready_idle", snk_ready, 1'b1);
    send_beat(1'b1, 1'b1, make_beat(32'h100));
    for (int i = 0; i < LANES; i++) begin
      check_val($sformatf("t1_we%0d", i), core_data_we, 1'b1);
      check_val($sformatf("t1_addr%0d", i), core_data_addr, 64'(i));
      check_val($sformatf("t1_din%0d", i), core_data_din, 64'(32'h100 + i));
      check_val($sformatf("t1_ready%0d", i), snk_ready, 1'b0);
      tick();
    end
    check_val("t1_ready_back", snk_ready, 1'b1);
    check_val("t1_pkt_cnt", snk_pkt_cnt, STATS ? 64'd1 : 64'd0);
    for (int i = 0; i < LANES; i++) check_val($sformatf("t1_mem%0d", i), mem[i], 64'(32'h100 + i));

    // Host writes on alternate cycles steal half the slots; sink continues at word 16.
    send_beat(1'b0, 1'b1, make_beat(32'h200));
    for (int c = 1; c <= 32; c++) begin
      if (c % 2 == 1) begin
        data_addr = 32'(40 + (c - 1) / 2);
        data_din  = 32'(32'hA000 + (c - 1) / 2);
        data_we   = 1'b1;
      end else begin
        data_we   = 1'b0;
      end
      #1;
      check_val($sformatf("t2_ready_c%0d", c), snk_ready, 1'b0);
      if (c % 2 == 1) check_val($sformatf("t2_host_addr_c%0d", c), core_data_addr, 64'(40 + (c - 1) / 2));
      else            check_val($sformatf("t2_snk_addr_c%0d", c), core_data_addr, 64'(16 + c / 2 - 1));
      tick();
    end
    data_we = 1'b0;
    #1;
    check_val("t2_ready_back", snk_ready, 1'b1);
    for (int i = 0; i < LANES; i++) check_val($sformatf("t2_snk_mem%0d", i), mem[16+i], 64'(32'h200 + i));
    for (int k = 0; k < 16; k++) check_val($sformatf("t2_host_mem%0d", k), mem[40+k], 64'(32'hA000 + k));
    check_val("t2_pkt_cnt", snk_pkt_cnt, STATS ? 64'd2 : 64'd0);

    for (int i = 0; i < 64; i++) host_wr(32'(i), 32'(i));

    // Two-beat source packet with host reads interleaved every third cycle.
    src_len = 16'd2;
    src_req = 1'b1;
    tick();
    src_req = 1'b0;
    #1;
    check_val("t3_busy", src_busy, 1'b1);
    beats = 0; p0_v = 1'b0; p1_v = 1'b0; p0_a = '0; p1_a = '0;
    for (int cyc = 0; cyc < 400 && beats < 2; cyc++) begin
      host_rd   = (cyc % 3 == 1);
      data_oe   = host_rd;
      data_addr = 32'(32 + cyc % 32);
      #1;
      if (p1_v) check_val($sformatf("t4_host_q_cyc%0d", cyc), data_q, p1_a);
      if (src_valid) begin
        check_val($sformatf("t3_sop_b%0d", beats), src_sop, beats == 0);
        check_val($sformatf("t3_eop_b%0d", beats), src_eop, beats == 1);
        for (int i = 0; i < LANES; i++)
          check_val($sformatf("t3_b%0d_lane%0d", beats, i), src_q[i*WORD_W +: WORD_W], 64'(beats * 16 + i));
        beats++;
      end
      tick();
      p1_v = p0_v; p1_a = p0_a;
      p0_v = host_rd; p0_a = data_addr;
    end
    data_oe = 1'b0;
    #1;
    check_val("t3_beats", beats, 2);
    check_val("t3_busy_fall", src_busy, 1'b0);
    check_val("t3_valid_one_cycle", src_valid, 1'b0);

    // Zero-length request completes with no beat.
    src_len = 16'd0;
    src_req = 1'b1;
    tick();
    src_req = 1'b0;
    #1;
    check_val("t3_len0_busy", src_busy, 1'b0);
    seen = 1'b0;
    repeat (6) begin
      if (src_valid) seen = 1'b1;
      tick();
    end
    check_val("t3_len0_novalid", seen, 1'b0);
    check_val("t3_src_pkt_cnt", src_pkt_cnt, STATS ? 64'd1 : 64'd0);

    // Beats offered during drain are dropped.
    send_beat(1'b1, 1'b1, make_beat(32'h300));
    snk_din   = make_beat(32'hDEAD0000);
    snk_sop   = 1'b1;
    snk_valid = 1'b1;
    repeat (3) tick();
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    wait_ready("t5_drain_done");
    check_val("t5_drop_cnt", snk_drop_cnt, STATS ? 64'd3 : 64'd0);
    for (int i = 0; i < LANES; i++) check_val($sformatf("t5_mem%0d", i), mem[i], 64'(32'h300 + i));
    for (int i = 0; i < LANES; i++) check_val($sformatf("t5_untouched%0d", i), mem[16+i], 64'(16 + i));

    // Reset in the middle of a sink drain and a source read.
    src_len = 16'd1;
    src_req = 1'b1;
    send_beat(1'b0, 1'b0, make_beat(32'h400));
    src_req = 1'b0;
    repeat (3) tick();
    check_val("t6_pre_we", core_data_we, 1'b1);
    check_val("t6_pre_busy", src_busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_val("t6_rst_we", core_data_we, 1'b0);
    check_val("t6_rst_oe", core_data_oe, 1'b0);
    check_val("t6_rst_addr", core_data_addr, 0);
    check_val("t6_rst_busy", src_busy, 1'b0);
    check_val("t6_rst_valid", src_valid, 1'b0);
    check_val("t6_rst_src_q", src_q[63:0], 0);
    check_val("t6_rst_ready", snk_ready, 1'b1);
    check_val("t6_rst_snk_pkt", snk_pkt_cnt, 0);
    check_val("t6_rst_drop", snk_drop_cnt, 0);
    tick();
    reset = 1'b0;
    tick();
    check_val("t6_ready_rel", snk_ready, 1'b1);
    send_beat(1'b0, 1'b1, make_beat(32'h500));
    check_val("t6_snk_base_addr", core_data_addr, 0);
    check_val("t6_snk_base_din", core_data_din, 64'h500);
    wait_ready("t6_drain_done");
    src_len = 16'd1;
    src_req = 1'b1;
    tick();
    src_req = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      #1;
      if (src_valid) begin
        seen = 1'b1;
        check_val("t6_len1_sop", src_sop, 1'b1);
        check_val("t6_len1_eop", src_eop, 1'b1);
        for (int i = 0; i < LANES; i++)
          check_val($sformatf("t6_src_lane%0d", i), src_q[i*WORD_W +: WORD_W], 64'(32'h500 + i));
      end
      tick();
    end
    check_val("t6_src_seen", seen, 1'b1);
    #1;
    check_val("t6_busy_after", src_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_stream_bridge.md
Name: dmem_stream_bridge

Overview:
Parametrised successor to the fixed 512/32 sink/source converters and their data-port mux around the core. Arbitrates the core data-memory port between host, a sink stream engine (wide beats to word writes) and a source stream engine (word reads to wide beats). Adds sink backpressure, packet length control, read-latency tagging and lossless host priority. Sits between host, stream fabric and the core's data port.

Parameters:
STREAM_W, 512, stream beat width; integer multiple of WORD_W
WORD_W, 32, core data word width
ADDR_W, 32, core data address width
RD_LAT, 1, core data_q latency in cycles after data_oe (1..4)
SNK_BASE, 0, first word address written by a sink packet
SRC_BASE, 0, first word address read for a source packet
LEN_W, 16, width of source beat-count input

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
data_addr  in  ADDR_W  host word address
data_din  in  WORD_W  host write data
data_we  in  1  host write strobe
data_oe  in  1  host read strobe
data_q  out  WORD_W  host read data (= core_data_q)
snk_sop  in  1  sink start of packet
snk_eop  in  1  sink end of packet
snk_valid  in  1  sink beat valid
snk_din  in  STREAM_W  sink beat
snk_ready  out  1  sink may present beat
src_req  in  1  source start request (pulse)
src_len  in  LEN_W  source beats, latched with src_req
src_sop  out  1  source start of packet
src_eop  out  1  source end of packet
src_valid  out  1  source beat valid
src_q  out  STREAM_W  source beat
src_busy  out  1  source engine active
core_data_addr  out  ADDR_W  to core
core_data_din  out  WORD_W  to core
core_data_we  out  1  to core
core_data_oe  out  1  to core
core_data_q  in  WORD_W  from core
snk_pkt_cnt  out  32  completed sink packets (stats)
src_pkt_cnt  out  32  completed source packets (stats)
snk_drop_cnt  out  32  beats offered while snk_ready=0 (stats)

Behaviour:
- LANES = STREAM_W/WORD_W. Lane i = bits [i*WORD_W +: WORD_W], goes to address base+i; lane 0 lowest.
- Reset: all outputs 0 except snk_ready=1; FSMs IDLE; partial packets discarded.
- Arbitration per cycle, fixed: host (data_we|data_oe) > sink > source. Losing engine holds its address and state. Host access is never delayed or dropped.
- Sink FSM IDLE/DRAIN. In IDLE snk_ready=1; beat accepted on snk_valid. Accept captures snk_din and sets word pointer: SNK_BASE if snk_sop, else continues after the previous beat. DRAIN issues LANES writes, one per granted cycle, snk_ready=0, then returns to IDLE. Minimum LANES+1 cycles per beat. snk_eop on accepted beat increments snk_pkt_cnt when its drain completes. snk_valid while snk_ready=0 is ignored and increments snk_drop_cnt. snk_sop mid-packet restarts at SNK_BASE.
- Source FSM IDLE/READ/EMIT. src_req in IDLE latches src_len, pointer=SRC_BASE, src_busy=1; src_len=0 completes immediately with no beat. src_req while busy is ignored. READ issues LANES reads on granted cycles. A RD_LAT-deep tag shift register marks own reads; data is captured only when the tag exits, so host reads never corrupt lanes. When all lanes have returned, EMIT drives src_valid=1 for exactly one cycle. src_sop is set on the first beat and src_eop on the last, both on one beat when len=1. Then READ again or IDLE; src_pkt_cnt increments on eop. No backpressure on source.
- Address arithmetic wraps modulo 2^ADDR_W. Beat counter is LEN_W bits.
- core_data_din = host data_din when host granted, else sink lane.

Optional Feature:
DMEM_BRIDGE_STATS_EN: defined -> the three 32-bit counters are live, saturating at all-ones, cleared by reset. Undefined -> counter logic omitted; ports driven constant 0.

Decomposition:
Package dmem_bridge_pkg: sink/source state enums, grant enum (GNT_NONE/HOST/SNK/SRC), LANES and lane-index-width functions. One natural sub-module, dmem_stream_src: the source FSM plus RD_LAT tag pipe and lane assembly. Sink engine and arbiter stay in the top.

Test Plan:
- Sink 1-beat sop+eop, lanes k=0x100+i, no host traffic -> 16 writes to addr 0..15, data 0x100..0x10F in consecutive cycles; snk_ready low 16 cycles; snk_pkt_cnt=1.
- Host data_we held every other cycle during sink drain -> all host writes land unchanged; sink finishes in 32 cycles with correct data.
- Preload mem[i]=i. src_req, src_len=2 -> two beats, lanes 0..15 then 16..31; sop on beat 1, eop on beat 2; src_busy falls after eop.
- RD_LAT=2, host data_oe interleaved with a source read -> source lanes match memory; host data_q returns its own addresses.
- snk_valid asserted while snk_ready=0 for 3 cycles -> beats dropped, snk_drop_cnt=3 (STATS_EN), memory unaffected.
- Reset asserted mid-DRAIN and mid-READ -> outputs 0 asynchronously, snk_ready=1 on release; next packet starts at base addresses.
